// File: rtl/kv_cache_attention.sv
// Causal multi-head attention over an on-chip KV cache with a power-of-two softmax approximation.
// Optional macro KV_SLIDING_WINDOW_EN: a full cache overwrites its oldest entry instead of flagging overflow.
module kv_cache_attention #(
  parameter int unsigned EMBED_DIM   = 8,
  parameter int unsigned NUM_HEADS   = 2,
  parameter int unsigned HEAD_DIM    = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MAX_SEQ     = 8,
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic                            clear_cache,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] q_in,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] k_in,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] v_in,
  output logic [EMBED_DIM*DATA_WIDTH-1:0] y_out,
  output logic                            valid_out,
  output logic [$clog2(MAX_SEQ):0]        seq_len,
  output logic                            overflow
);
  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned VW  = EMBED_DIM * DW;
  localparam int unsigned HSW = HEAD_DIM * DW;
  localparam int unsigned PW  = $clog2(MAX_SEQ);
  localparam int unsigned SLW = PW + 1;
  localparam int unsigned SW  = 2 * DW;
  localparam int unsigned WW  = 9;
  localparam int unsigned WSW = PW + 9;
  localparam int unsigned AW  = 2 * DW + PW + 1;
  localparam int unsigned PRW = DW + WW + 1;
  localparam int unsigned EIW = $clog2(HEAD_DIM) + 1;
  localparam int unsigned IW  = (SLW > EIW) ? SLW : EIW;
  localparam int unsigned HCW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int          YMAX = (1 << (DW - 1)) - 1;
  localparam int          YMIN = -(1 << (DW - 1));
`ifdef KV_SLIDING_WINDOW_EN
  localparam bit SLIDING = 1'b1;
`else
  localparam bit SLIDING = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, APPEND, SCORE, WEIGHT, ACCUM, NORM, DONE} state_t;

  state_t state, state_next;

  logic [VW-1:0]          k_mem [MAX_SEQ];
  logic [VW-1:0]          v_mem [MAX_SEQ];
  logic signed [SW-1:0]   s_mem [MAX_SEQ];
  logic [WW-1:0]          w_mem [MAX_SEQ];
  logic [VW-1:0]          q_lat, k_lat, v_lat;
  logic signed [SW-1:0]   m;
  logic [WSW-1:0]         wsum;
  logic signed [AW-1:0]   acc [HEAD_DIM];
  logic [PW-1:0]          wr_ptr;
  logic [IW-1:0]          idx;
  logic [HCW-1:0]         head;

  logic [PW-1:0]          pos_c;
  logic                   full_c, append_we_c, last_pos_c, last_elem_c, last_head_c;
  logic [HSW-1:0]         hq_c, hk_c, hv_c;
  logic signed [SW-1:0]   qk_c [HEAD_DIM];
  logic signed [SW-1:0]   dot_c, s_c, diff_c, delta_c;
  logic [WW-1:0]          w_c;
  logic signed [PRW-1:0]  prd_c [HEAD_DIM];
  logic signed [AW-1:0]   acc_sel_c, wsum_ext_c, quo_c;
  logic [DW-1:0]          y_c;

  assign pos_c       = idx[PW-1:0];
  assign full_c      = (seq_len == SLW'(MAX_SEQ));
  assign append_we_c = (state == APPEND) && (!full_c || SLIDING);
  assign last_pos_c  = (idx == IW'(seq_len) - IW'(1));
  assign last_elem_c = (idx == IW'(HEAD_DIM - 1));
  assign last_head_c = (head == HCW'(NUM_HEADS - 1));

  // Head-slice selection of the latched query and the cache entry under the position counter
  always_comb begin
    hq_c = '0;
    hk_c = '0;
    hv_c = '0;
    for (int h = 0; h < NUM_HEADS; h++) begin
      if (head == HCW'(h)) begin
        hq_c = q_lat[h*HSW +: HSW];
        hk_c = k_mem[pos_c][h*HSW +: HSW];
        hv_c = v_mem[pos_c][h*HSW +: HSW];
      end
    end
  end

  // Score, weight and weighted-value arithmetic for the current position
  always_comb begin
    dot_c = '0;
    for (int d = 0; d < HEAD_DIM; d++) begin
      qk_c[d]  = SW'($signed(hq_c[d*DW +: DW])) * SW'($signed(hk_c[d*DW +: DW]));
      dot_c    = dot_c + qk_c[d];
      prd_c[d] = PRW'($signed({1'b0, w_mem[pos_c]})) * PRW'($signed(hv_c[d*DW +: DW]));
    end
    s_c     = dot_c >>> (8 + SCALE_SHIFT);
    diff_c  = m - s_mem[pos_c];
    delta_c = diff_c >>> 8;
    w_c     = (delta_c >= SW'(9)) ? '0 : (WW'(256) >> delta_c);
  end

  // Normalisation: truncating signed divide followed by saturation
  always_comb begin
    acc_sel_c = '0;
    for (int d = 0; d < HEAD_DIM; d++) begin
      if (idx == IW'(d)) acc_sel_c = acc[d];
    end
    wsum_ext_c = (wsum == '0) ? AW'(1) : AW'(wsum);
    quo_c      = acc_sel_c / wsum_ext_c;
    if (quo_c > AW'(YMAX))      y_c = DW'(YMAX);
    else if (quo_c < AW'(YMIN)) y_c = DW'(YMIN);
    else                        y_c = quo_c[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in) state_next = APPEND;
      APPEND:  state_next = SCORE;
      SCORE:   if (last_pos_c) state_next = WEIGHT;
      WEIGHT:  if (last_pos_c) state_next = ACCUM;
      ACCUM:   if (last_pos_c) state_next = NORM;
      NORM:    if (last_elem_c) state_next = last_head_c ? DONE : SCORE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cache and scratch storage; contents need no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && valid_in) begin
      q_lat <= q_in;
      k_lat <= k_in;
      v_lat <= v_in;
    end
    if (append_we_c) begin
      k_mem[wr_ptr] <= k_lat;
      v_mem[wr_ptr] <= v_lat;
    end
    if (state == SCORE)  s_mem[pos_c] <= s_c;
    if (state == WEIGHT) w_mem[pos_c] <= w_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_in  <= 1'b1;
      valid_out <= 1'b0;
      y_out     <= '0;
      seq_len   <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      idx       <= '0;
      head      <= '0;
      m         <= '0;
      wsum      <= '0;
      for (int d = 0; d < HEAD_DIM; d++) acc[d] <= '0;
    end else begin
      ready_in  <= (state_next == IDLE);
      valid_out <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (clear_cache) begin
            seq_len  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
          end
        end
        APPEND: begin
          idx  <= '0;
          head <= '0;
          wsum <= '0;
          for (int d = 0; d < HEAD_DIM; d++) acc[d] <= '0;
          if (append_we_c) wr_ptr  <= wr_ptr + PW'(1);
          if (!full_c)     seq_len <= seq_len + SLW'(1);
          if (full_c && !SLIDING) overflow <= 1'b1;
        end
        SCORE: begin
          if (idx == '0 || s_c > m) m <= s_c;
          idx <= last_pos_c ? '0 : idx + IW'(1);
        end
        WEIGHT: begin
          wsum <= wsum + WSW'(w_c);
          idx  <= last_pos_c ? '0 : idx + IW'(1);
        end
        ACCUM: begin
          for (int d = 0; d < HEAD_DIM; d++) acc[d] <= acc[d] + AW'(prd_c[d]);
          idx <= last_pos_c ? '0 : idx + IW'(1);
        end
        NORM: begin
          for (int h = 0; h < NUM_HEADS; h++) begin
            for (int d = 0; d < HEAD_DIM; d++) begin
              if (head == HCW'(h) && idx == IW'(d)) y_out[(h*HEAD_DIM+d)*DW +: DW] <= y_c;
            end
          end
          idx <= last_elem_c ? '0 : idx + IW'(1);
          if (last_elem_c) begin
            head <= last_head_c ? '0 : head + HCW'(1);
            wsum <= '0;
            for (int d = 0; d < HEAD_DIM; d++) acc[d] <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kv_cache_attention.sv
// Bench for kv_cache_attention: directed vector table, abort-on-reset sequence, then random tokens vs a reference model.
`timescale 1ns/1ps
module tb_kv_cache_attention;
  localparam int unsigned EMBED_DIM   = 8;
  localparam int unsigned NUM_HEADS   = 2;
  localparam int unsigned HEAD_DIM    = 4;
  localparam int unsigned DW          = 16;
  localparam int unsigned MS          = 4;
  localparam int unsigned SCALE_SHIFT = 1;
  localparam int unsigned EW          = EMBED_DIM * DW;
  localparam int unsigned SLW         = $clog2(MS) + 1;

  logic           clk = 1'b0;
  logic           rst, valid_in, clear_cache;
  logic           ready_in, valid_out, overflow;
  logic [EW-1:0]  q_in, k_in, v_in, y_out;
  logic [SLW-1:0] seq_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kv_cache_attention #(
    .EMBED_DIM(EMBED_DIM), .NUM_HEADS(NUM_HEADS), .HEAD_DIM(HEAD_DIM),
    .DATA_WIDTH(DW), .MAX_SEQ(MS), .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .clear_cache(clear_cache), .q_in(q_in), .k_in(k_in), .v_in(v_in),
    .y_out(y_out), .valid_out(valid_out), .seq_len(seq_len), .overflow(overflow)
  );

  typedef struct {
    bit            clr;
    logic [EW-1:0] q, k, v, y;
    int            sl;
    bit            ov;
  } vec_t;

  // Reference cache: plain arrays plus a fill count and write slot
  logic signed [DW-1:0] mk_k [MS][EMBED_DIM];
  logic signed [DW-1:0] mk_v [MS][EMBED_DIM];
  int m_sl, m_wp;
  bit m_ov;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] splat(input logic [DW-1:0] x);
    logic [EW-1:0] r;
    for (int e = 0; e < EMBED_DIM; e++) r[e*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [EW-1:0] ramp();
    logic [EW-1:0] r;
    for (int e = 0; e < EMBED_DIM; e++) r[e*DW +: DW] = DW'((e + 1) * 256);
    return r;
  endfunction

  function automatic logic [EW-1:0] rnd_vec(input int span);
    logic [EW-1:0] r;
    for (int e = 0; e < EMBED_DIM; e++) r[e*DW +: DW] = DW'(int'($urandom_range(0, 2*span - 1)) - span);
    return r;
  endfunction

  function automatic vec_t mk(input bit clr, input logic [EW-1:0] q, k, v, y, input int sl, input bit ov);
    vec_t t;
    t.clr = clr; t.q = q; t.k = k; t.v = v; t.y = y; t.sl = sl; t.ov = ov;
    return t;
  endfunction

  function automatic void model_reset();
    m_sl = 0; m_wp = 0; m_ov = 1'b0;
  endfunction

  function automatic void model_push(input bit clr, input logic [EW-1:0] k, v);
    bit store;
    if (clr) model_reset();
    store = 1'b1;
    if (m_sl == MS) begin
`ifdef KV_SLIDING_WINDOW_EN
      store = 1'b1;
`else
      store = 1'b0;
      m_ov  = 1'b1;
`endif
    end else begin
      m_sl++;
    end
    if (store) begin
      for (int e = 0; e < EMBED_DIM; e++) begin
        mk_k[m_wp][e] = k[e*DW +: DW];
        mk_v[m_wp][e] = v[e*DW +: DW];
      end
      m_wp = (m_wp + 1) % MS;
    end
  endfunction

  // Attention over the reference cache with integer arithmetic
  function automatic logic [EW-1:0] model_attend(input logic [EW-1:0] q);
    logic [EW-1:0] y;
    logic signed [DW-1:0] qe;
    longint s [MS];
    longint w [MS];
    longint dot, mx, wsum, acc, delta, yv;
    y = '0;
    for (int h = 0; h < NUM_HEADS; h++) begin
      for (int p = 0; p < m_sl; p++) begin
        dot = 0;
        for (int d = 0; d < HEAD_DIM; d++) begin
          qe  = q[(h*HEAD_DIM + d)*DW +: DW];
          dot += longint'(qe) * longint'(mk_k[p][h*HEAD_DIM + d]);
        end
        s[p] = dot >>> (8 + SCALE_SHIFT);
      end
      mx = s[0];
      for (int p = 1; p < m_sl; p++) if (s[p] > mx) mx = s[p];
      wsum = 0;
      for (int p = 0; p < m_sl; p++) begin
        delta = (mx - s[p]) / 256;
        w[p]  = (delta >= 9) ? 0 : 256 / (longint'(1) << delta);
        wsum += w[p];
      end
      for (int d = 0; d < HEAD_DIM; d++) begin
        acc = 0;
        for (int p = 0; p < m_sl; p++) acc += w[p] * longint'(mk_v[p][h*HEAD_DIM + d]);
        yv = acc / wsum;
        if (yv > 32767) yv = 32767;
        if (yv < -32768) yv = -32768;
        y[(h*HEAD_DIM + d)*DW +: DW] = DW'(yv);
      end
    end
    return y;
  endfunction

  task automatic send(input bit clr, input logic [EW-1:0] q, k, v, output logic [EW-1:0] y, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    valid_in = 1'b1; clear_cache = clr; q_in = q; k_in = k; v_in = v;
    @(posedge clk);
    #1;
    valid_in = 1'b0; clear_cache = 1'b0;
    q_in = rnd_vec(30000); k_in = rnd_vec(30000); v_in = rnd_vec(30000);
    chk("busy_ready", EW'(ready_in), EW'(0));
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        lat = i + 2;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: valid_out got 0 for 400 cycles expected a pulse");
    end
    y = y_out;
    @(posedge clk);
    #1;
    chk("pulse_width", EW'(valid_out), EW'(0));
  endtask

  vec_t          vt [12];
  logic [EW-1:0] y, q, k, v, ey, ca, cb;
  int            lat;
  bit            clr, seen;

  initial begin
    rst = 1'b1; valid_in = 1'b0; clear_cache = 1'b0;
    q_in = '0; k_in = '0; v_in = '0;
    ca = 128'h0123_0456_ff00_0080_0200_fe00_0010_0300;
    cb = 128'h0100_0200_0300_0400_fc00_0080_0001_ffff;

    vt[0]  = mk(1'b1, ca, cb, ramp(), ramp(), 1, 1'b0);
    vt[1]  = mk(1'b1, '0, '0, splat(16'h0100), splat(16'h0100), 1, 1'b0);
    vt[2]  = mk(1'b0, '0, ca, splat(16'h0300), splat(16'h0200), 2, 1'b0);
    vt[3]  = mk(1'b1, '0, '0, splat(16'h0300), splat(16'h0300), 1, 1'b0);
    vt[4]  = mk(1'b0, 128'h0100, 128'h0200, '0,
                128'h0180_0180_0180_0180_0100_0100_0100_0100, 2, 1'b0);
    vt[5]  = mk(1'b1, cb, ca, splat(16'hff00), splat(16'hff00), 1, 1'b0);
    vt[6]  = mk(1'b0, '0, cb, splat(16'h0080), splat(16'hffc0), 2, 1'b0);
    vt[7]  = mk(1'b1, '0, ca, splat(16'h0800), splat(16'h0800), 1, 1'b0);
    vt[8]  = mk(1'b0, '0, cb, splat(16'h0100), splat(16'h0480), 2, 1'b0);
    vt[9]  = mk(1'b0, '0, ca, splat(16'h0100), splat(16'h0355), 3, 1'b0);
    vt[10] = mk(1'b0, '0, cb, splat(16'h0100), splat(16'h02c0), 4, 1'b0);
`ifdef KV_SLIDING_WINDOW_EN
    vt[11] = mk(1'b0, '0, ca, splat(16'h0500), splat(16'h0200), 4, 1'b0);
`else
    vt[11] = mk(1'b0, '0, ca, splat(16'h0500), splat(16'h02c0), 4, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_y_out", y_out, '0);
    chk("rst_valid_out", EW'(valid_out), EW'(0));
    chk("rst_seq_len", EW'(seq_len), EW'(0));
    chk("rst_overflow", EW'(overflow), EW'(0));
    chk("rst_ready_in", EW'(ready_in), EW'(1));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send(vt[i].clr, vt[i].q, vt[i].k, vt[i].v, y, lat);
      chk($sformatf("vec%0d_y", i), y, vt[i].y);
      chk($sformatf("vec%0d_seq_len", i), EW'(seq_len), EW'(vt[i].sl));
      chk($sformatf("vec%0d_overflow", i), EW'(overflow), EW'(vt[i].ov));
      chk($sformatf("vec%0d_latency", i), EW'(lat), EW'(2 + NUM_HEADS * (3 * vt[i].sl + HEAD_DIM)));
    end

    // Abort a token with reset while head 1 is accumulating
    @(negedge clk);
    valid_in = 1'b1; clear_cache = 1'b1;
    q_in = rnd_vec(512); k_in = rnd_vec(512); v_in = rnd_vec(30000);
    @(posedge clk);
    #1;
    valid_in = 1'b0; clear_cache = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_in", EW'(ready_in), EW'(1));
    chk("abort_seq_len", EW'(seq_len), EW'(0));
    chk("abort_valid_out", EW'(valid_out), EW'(0));
    chk("abort_overflow", EW'(overflow), EW'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid_out) seen = 1'b1;
    end
    chk("abort_no_valid", EW'(seen), EW'(0));

    model_reset();
    q = rnd_vec(512); k = rnd_vec(512); v = rnd_vec(30000);
    send(1'b0, q, k, v, y, lat);
    model_push(1'b0, k, v);
    chk("post_abort_y", y, v);
    chk("post_abort_seq_len", EW'(seq_len), EW'(1));
    chk("post_abort_latency", EW'(lat), EW'(2 + NUM_HEADS * (3 + HEAD_DIM)));

    for (int i = 0; i < 40; i++) begin
      clr = ($urandom_range(0, 7) == 0);
      q = rnd_vec(512);
      k = rnd_vec(512);
      v = rnd_vec(32768);
      send(clr, q, k, v, y, lat);
      model_push(clr, k, v);
      ey = model_attend(q);
      chk($sformatf("rnd%0d_y", i), y, ey);
      chk($sformatf("rnd%0d_seq_len", i), EW'(seq_len), EW'(m_sl));
      chk($sformatf("rnd%0d_overflow", i), EW'(overflow), EW'(m_ov));
      chk($sformatf("rnd%0d_latency", i), EW'(lat), EW'(2 + NUM_HEADS * (3 * m_sl + HEAD_DIM)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
